tdc_channel_arbiter: RTL and testbench
======================================

Name: tdc_channel_arbiter

Overview:
Round-robin arbiter that shares one thermometer-decode/processing unit among N_CH TDC capture channels.
Each channel's enabler/capture logic raises a level request holding its raw capture word. The arbiter latches the word, starts the processing unit, waits for its result, then pulses that channel's processing_ended (ch_done) so the enabler can re-arm.
A watchdog stops a hung processing unit from locking out every channel.

Parameters:
N_CH, 4, number of capture channels (2..16)
DATA_W, 32, width of one raw capture word
TIMEOUT, 255, maximum cycles spent in WAIT before abort (1..65535)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
ch_req  in  N_CH  per-channel level request; held high until the matching ch_done
ch_data  in  N_CH*DATA_W  capture words; channel k occupies bits [k*DATA_W +: DATA_W]
ch_done  out  N_CH  one-cycle pulse to the served channel (drives its processing_ended)
proc_start  out  1  one-cycle start pulse to the processing unit
proc_data  out  DATA_W  latched capture word, stable from proc_start until the next grant
proc_ch  out  max(1,clog2(N_CH))  index of the granted channel, stable with proc_data
proc_valid  in  1  processing unit finished (pulse)
grant  out  N_CH  one-hot grant; zero in IDLE
busy  out  1  high in every state except IDLE
timeout_err  out  1  one-cycle pulse when the watchdog fires

Behaviour:
- All outputs are registered.
- Reset values: state IDLE; ch_done, proc_start, grant, busy and timeout_err all 0; proc_data and proc_ch 0; wait counter 0; round-robin pointer last = N_CH-1, so channel 0 has first priority.
- Reset asserted mid-operation aborts the current service immediately. No ch_done and no timeout_err are issued. The pending channel is re-served after reset if its request is still high.
- States:
  - IDLE:
    - If any ch_req is high, select the first requesting index searching last+1, last+2, … modulo N_CH.
    - Register grant, proc_ch and proc_data (sampled ch_data of the winner).
    - Set proc_start=1 and busy=1; go ISSUE.
    - Otherwise stay in IDLE.
  - ISSUE (1 cycle):
    - proc_start is high during this cycle.
    - Clear the wait counter and go WAIT.
    - proc_valid is ignored in this cycle; the processing unit guarantees at least 1 cycle of latency.
  - WAIT:
    - If proc_valid=1: set ch_done[grant]=1 and go RELEASE.
    - Else if counter == TIMEOUT-1: set timeout_err=1 and ch_done[grant]=1, then go RELEASE. The channel is released so its enabler re-arms.
    - Else increment the counter.
    - proc_valid and timeout in the same cycle: proc_valid wins and no timeout_err is issued.
  - RELEASE (1 cycle):
    - ch_done and timeout_err are high this cycle.
    - Set last = proc_ch, clear grant and busy, and go IDLE.
- Latency: req sampled high in IDLE at cycle t gives proc_start high at t+1. proc_valid at cycle w gives ch_done high at w+1. Back-to-back service: the next proc_start comes 2 cycles after ch_done.
- ch_req dropping while granted is ignored; the service completes and ch_done is still pulsed.
- ch_data changes after the grant do not affect proc_data.
- A request that stays high through RELEASE competes again in IDLE, but at lowest priority because of the pointer update.
- Only one ch_done bit is ever high, and only for exactly one cycle per grant.
- proc_valid outside WAIT is ignored.
- Invalid or unreachable state encoding returns to IDLE with all outputs cleared.

Test Plan:
- Reset, then ch_req=0001, ch_data[0]=0xA5A5_0001, proc_valid 3 cycles after proc_start -> proc_start one cycle after the request, proc_data=0xA5A5_0001, proc_ch=0, ch_done=0001 one cycle after proc_valid, busy then drops to 0.
- ch_req=1111 held and each service completed -> grant order 0,1,2,3,0; each ch_done bit pulses once per service.
- ch_req=0101 with channel 0 re-requesting immediately -> order 0,2,0,2; channel 0 is never served twice in a row while channel 2 is pending.
- TIMEOUT=8 and proc_valid never asserted -> exactly 8 WAIT cycles, then timeout_err and ch_done[granted] pulse together; the next request is granted normally.
- proc_valid asserted on the same cycle the counter reaches TIMEOUT-1 -> ch_done pulses and timeout_err stays 0.
- rst asserted during WAIT for channel 1 with ch_req=0010 held -> no ch_done; after rst is released, channel 1 proc_start comes 1 cycle after its request is sampled in IDLE, since channel 0 is idle and the pointer has reset.

Source files
------------

// File: rtl/tdc_channel_arbiter_if.sv
// Channel/processing-unit handshake bundle for tdc_channel_arbiter.
// master = arbiter side, slave = channel enablers plus processing unit.
`timescale 1ns/1ps
interface tdc_channel_arbiter_if #(
  parameter int N_CH   = 4,
  parameter int DATA_W = 32
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [N_CH-1:0]        ch_req;
  logic [N_CH*DATA_W-1:0] ch_data;
  logic [N_CH-1:0]        ch_done;
  logic                   proc_start;
  logic [DATA_W-1:0]      proc_data;
  logic [CH_W-1:0]        proc_ch;
  logic                   proc_valid;

  modport master (
    input  ch_req, ch_data, proc_valid,
    output ch_done, proc_start, proc_data, proc_ch
  );

  modport slave (
    output ch_req, ch_data, proc_valid,
    input  ch_done, proc_start, proc_data, proc_ch
  );
endinterface

// File: rtl/tdc_channel_arbiter.sv
// Round-robin arbiter sharing one TDC processing unit among N_CH capture
// channels, with a watchdog that releases a channel if the unit hangs.
`timescale 1ns/1ps
module tdc_channel_arbiter #(
  parameter int N_CH    = 4,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  tdc_channel_arbiter_if.master     bus,
  output logic [N_CH-1:0]           grant,
  output logic                      busy,
  output logic                      timeout_err
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t            state, state_n;
  logic [15:0]       cnt, cnt_n;
  logic [CH_W-1:0]   last, last_n;

  logic              found;
  logic [CH_W-1:0]   win;
  logic [DATA_W-1:0] win_data;

  logic [N_CH-1:0]   grant_n, ch_done_n;
  logic              busy_n, timeout_n, proc_start_n;
  logic [DATA_W-1:0] proc_data_n;
  logic [CH_W-1:0]   proc_ch_n;

  logic              at_limit;
  assign at_limit = (cnt == 16'(TIMEOUT - 1));

  // Two passes instead of a modulo walk: indices above last first, then wrap.
  always_comb begin
    found    = 1'b0;
    win      = '0;
    win_data = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (!found && bus.ch_req[k] && (k > 32'(last))) begin
        found    = 1'b1;
        win      = CH_W'(k);
        win_data = bus.ch_data[k*DATA_W +: DATA_W];
      end
    end
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (!found && bus.ch_req[k] && (k <= 32'(last))) begin
        found    = 1'b1;
        win      = CH_W'(k);
        win_data = bus.ch_data[k*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = IDLE;
    case (state)
      IDLE:    state_n = found ? ISSUE : IDLE;
      ISSUE:   state_n = WAIT;
      WAIT:    state_n = (bus.proc_valid || at_limit) ? RELEASE : WAIT;
      RELEASE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    grant_n      = grant;
    busy_n       = busy;
    proc_data_n  = bus.proc_data;
    proc_ch_n    = bus.proc_ch;
    cnt_n        = cnt;
    last_n       = last;
    ch_done_n    = '0;
    timeout_n    = 1'b0;
    proc_start_n = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          grant_n      = N_CH'(1) << win;
          proc_ch_n    = win;
          proc_data_n  = win_data;
          proc_start_n = 1'b1;
          busy_n       = 1'b1;
        end
      end
      ISSUE: cnt_n = '0;
      WAIT: begin
        if (bus.proc_valid) begin
          ch_done_n = grant;
        end else if (at_limit) begin
          ch_done_n = grant;
          timeout_n = 1'b1;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      RELEASE: begin
        last_n  = bus.proc_ch;
        grant_n = '0;
        busy_n  = 1'b0;
      end
      default: begin
        grant_n     = '0;
        busy_n      = 1'b0;
        proc_data_n = '0;
        proc_ch_n   = '0;
        cnt_n       = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant          <= '0;
      busy           <= 1'b0;
      timeout_err    <= 1'b0;
      bus.ch_done    <= '0;
      bus.proc_start <= 1'b0;
      bus.proc_data  <= '0;
      bus.proc_ch    <= '0;
      cnt            <= '0;
      last           <= CH_W'(N_CH - 1);
    end else begin
      grant          <= grant_n;
      busy           <= busy_n;
      timeout_err    <= timeout_n;
      bus.ch_done    <= ch_done_n;
      bus.proc_start <= proc_start_n;
      bus.proc_data  <= proc_data_n;
      bus.proc_ch    <= proc_ch_n;
      cnt            <= cnt_n;
      last           <= last_n;
    end
  end
endmodule

// File: tb/tb_tdc_channel_arbiter.sv
// Directed bench for tdc_channel_arbiter (N_CH=4, DATA_W=32, TIMEOUT=8).
`timescale 1ns/1ps
module tb_tdc_channel_arbiter;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] grant;
  logic       busy;
  logic       timeout_err;
  int         pass_cnt  = 0;
  int         total_cnt = 0;

  tdc_channel_arbiter_if #(.N_CH(4), .DATA_W(32)) bus ();

  tdc_channel_arbiter #(.N_CH(4), .DATA_W(32), .TIMEOUT(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .grant       (grant),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.ch_req = '0; bus.ch_data = '0; bus.proc_valid = 1'b0;
    apply_reset();
    total_cnt++;
    if ({grant, busy, timeout_err, bus.ch_done, bus.proc_start} !== 11'd0)
      $display("FAIL reset_ctrl got=%b exp=0", {grant, busy, timeout_err, bus.ch_done, bus.proc_start});
    else pass_cnt++;
    total_cnt++;
    if ({bus.proc_data, bus.proc_ch} !== 34'd0)
      $display("FAIL reset_data got=%h exp=0", {bus.proc_data, bus.proc_ch});
    else pass_cnt++;
  endtask

  task automatic test_single();
    bus.ch_data[0 +: 32] = 32'hA5A5_0001;
    bus.ch_req = 4'b0001;
    tick();
    total_cnt++;
    if ({bus.proc_start, busy, grant} !== 6'b11_0001)
      $display("FAIL single_start got=%b exp=110001", {bus.proc_start, busy, grant});
    else pass_cnt++;
    total_cnt++;
    if (bus.proc_data !== 32'hA5A5_0001 || bus.proc_ch !== 2'd0)
      $display("FAIL single_data got=%h/%0d exp=a5a50001/0", bus.proc_data, bus.proc_ch);
    else pass_cnt++;
    bus.ch_data[0 +: 32] = 32'hDEAD_BEEF;
    tick();
    tick();
    tick();
    bus.proc_valid = 1'b1;
    tick();
    bus.proc_valid = 1'b0;
    bus.ch_req = '0;
    total_cnt++;
    if (bus.ch_done !== 4'b0001 || timeout_err !== 1'b0)
      $display("FAIL single_done got=%b/%b exp=0001/0", bus.ch_done, timeout_err);
    else pass_cnt++;
    total_cnt++;
    if (bus.proc_data !== 32'hA5A5_0001)
      $display("FAIL single_hold got=%h exp=a5a50001", bus.proc_data);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({busy, bus.ch_done, grant} !== 9'd0)
      $display("FAIL single_idle got=%b exp=0", {busy, bus.ch_done, grant});
    else pass_cnt++;
  endtask

  task automatic test_round_robin();
    int exp_ch[5] = '{0, 1, 2, 3, 0};
    apply_reset();
    for (int k = 0; k < 4; k++) bus.ch_data[k*32 +: 32] = 32'h1000 + k;
    bus.ch_req = 4'b1111;
    tick();
    for (int i = 0; i < 5; i++) begin
      total_cnt++;
      if (bus.proc_start !== 1'b1 || bus.proc_ch !== 2'(exp_ch[i]) || grant !== 4'(1 << exp_ch[i]))
        $display("FAIL rr_grant[%0d] got=%b/%0d/%b exp=1/%0d", i, bus.proc_start, bus.proc_ch, grant, exp_ch[i]);
      else pass_cnt++;
      total_cnt++;
      if (bus.proc_data !== 32'h1000 + exp_ch[i])
        $display("FAIL rr_data[%0d] got=%h exp=%h", i, bus.proc_data, 32'h1000 + exp_ch[i]);
      else pass_cnt++;
      tick();
      bus.proc_valid = 1'b1;
      tick();
      bus.proc_valid = 1'b0;
      if (i == 4) bus.ch_req = '0;
      total_cnt++;
      if (bus.ch_done !== 4'(1 << exp_ch[i]))
        $display("FAIL rr_done[%0d] got=%b exp=%b", i, bus.ch_done, 4'(1 << exp_ch[i]));
      else pass_cnt++;
      tick();
      total_cnt++;
      if (bus.ch_done !== 4'b0000 || busy !== 1'b0)
        $display("FAIL rr_idle[%0d] got=%b/%b exp=0000/0", i, bus.ch_done, busy);
      else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_alternation();
    int exp_ch[4] = '{0, 2, 0, 2};
    apply_reset();
    bus.ch_req = 4'b0101;
    tick();
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (bus.proc_start !== 1'b1 || bus.proc_ch !== 2'(exp_ch[i]))
        $display("FAIL alt_grant[%0d] got=%b/%0d exp=1/%0d", i, bus.proc_start, bus.proc_ch, exp_ch[i]);
      else pass_cnt++;
      tick();
      bus.proc_valid = 1'b1;
      tick();
      bus.proc_valid = 1'b0;
      if (i == 3) bus.ch_req = '0;
      total_cnt++;
      if (bus.ch_done !== 4'(1 << exp_ch[i]))
        $display("FAIL alt_done[%0d] got=%b exp=%b", i, bus.ch_done, 4'(1 << exp_ch[i]));
      else pass_cnt++;
      tick();
      tick();
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    apply_reset();
    bus.ch_req = 4'b0100;
    tick();
    total_cnt++;
    if (bus.proc_start !== 1'b1 || bus.proc_ch !== 2'd2)
      $display("FAIL to_start got=%b/%0d exp=1/2", bus.proc_start, bus.proc_ch);
    else pass_cnt++;
    do begin
      tick();
      n++;
    end while (bus.ch_done === 4'b0000 && n < 20);
    total_cnt++;
    if (n !== 9)
      $display("FAIL to_latency got=%0d exp=9", n);
    else pass_cnt++;
    total_cnt++;
    if (timeout_err !== 1'b1 || bus.ch_done !== 4'b0100)
      $display("FAIL to_pulse got=%b/%b exp=1/0100", timeout_err, bus.ch_done);
    else pass_cnt++;
    bus.ch_req = '0;
    tick();
    total_cnt++;
    if (timeout_err !== 1'b0 || busy !== 1'b0)
      $display("FAIL to_clear got=%b/%b exp=0/0", timeout_err, busy);
    else pass_cnt++;
    bus.ch_req = 4'b0001;
    tick();
    total_cnt++;
    if (bus.proc_start !== 1'b1 || bus.proc_ch !== 2'd0)
      $display("FAIL to_next got=%b/%0d exp=1/0", bus.proc_start, bus.proc_ch);
    else pass_cnt++;
    tick();
    bus.proc_valid = 1'b1;
    tick();
    bus.proc_valid = 1'b0;
    bus.ch_req = '0;
    total_cnt++;
    if (bus.ch_done !== 4'b0001 || timeout_err !== 1'b0)
      $display("FAIL to_next_done got=%b/%b exp=0001/0", bus.ch_done, timeout_err);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_valid_at_limit();
    apply_reset();
    bus.ch_req = 4'b0010;
    tick();
    for (int i = 0; i < 8; i++) tick();
    total_cnt++;
    if (busy !== 1'b1 || bus.ch_done !== 4'b0000 || timeout_err !== 1'b0)
      $display("FAIL lim_wait got=%b/%b/%b exp=1/0000/0", busy, bus.ch_done, timeout_err);
    else pass_cnt++;
    bus.proc_valid = 1'b1;
    tick();
    bus.proc_valid = 1'b0;
    bus.ch_req = '0;
    total_cnt++;
    if (bus.ch_done !== 4'b0010 || timeout_err !== 1'b0)
      $display("FAIL lim_done got=%b/%b exp=0010/0", bus.ch_done, timeout_err);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    bus.ch_req = 4'b0010;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    total_cnt++;
    if ({bus.ch_done, timeout_err, busy, grant} !== 10'd0)
      $display("FAIL rstmid_abort got=%b exp=0", {bus.ch_done, timeout_err, busy, grant});
    else pass_cnt++;
    rst = 1'b0;
    tick();
    total_cnt++;
    if (bus.proc_start !== 1'b1 || bus.proc_ch !== 2'd1 || bus.ch_done !== 4'b0000)
      $display("FAIL rstmid_regrant got=%b/%0d/%b exp=1/1/0000", bus.proc_start, bus.proc_ch, bus.ch_done);
    else pass_cnt++;
    tick();
    bus.proc_valid = 1'b1;
    tick();
    bus.proc_valid = 1'b0;
    bus.ch_req = '0;
    total_cnt++;
    if (bus.ch_done !== 4'b0010)
      $display("FAIL rstmid_done got=%b exp=0010", bus.ch_done);
    else pass_cnt++;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_alternation();
    test_timeout();
    test_valid_at_limit();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not complete, passed=%0d total=%0d", pass_cnt, total_cnt);
    $fatal(1);
  end
endmodule
